// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_pkg
//  Description : Shared definitions for the sprite compositor: coordinate and
//                colour widths, game-state encodings, colour keys, per-state
//                background colours and a channel-halving helper.
//  Revision    : 1.0  initial release
// ============================================================================
package sprite_pkg;

    localparam int COORD_W  = 16;
    localparam int COLOUR_W = 24;
    localparam int GS_W     = 4;

    typedef enum logic [GS_W-1:0] {
        GS_START = 4'd0,
        GS_PLAY  = 4'd1,
        GS_PAUSE = 4'd2,
        GS_WIN   = 4'd3,
        GS_LOSE  = 4'd4
    } game_state_e;

    localparam logic [COLOUR_W-1:0] TRANSPARENT_KEY = 24'hFF0096;
    localparam logic [COLOUR_W-1:0] BG_PLAY         = 24'h2222EE;
    localparam logic [COLOUR_W-1:0] BG_WIN          = 24'h00AA00;
    localparam logic [COLOUR_W-1:0] BG_LOSE         = 24'hAA0000;

    // Dim a colour by halving each 8-bit channel independently, so no bit
    // leaks from one channel into the next.
    function automatic logic [COLOUR_W-1:0] halve_channels(input logic [COLOUR_W-1:0] c);
        return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
    endfunction

    // States in which sprites are drawn and collisions are recorded.
    function automatic logic is_active_state(input logic [GS_W-1:0] gs);
        return (gs >= GS_PLAY) && (gs <= GS_LOSE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : delay_line
//  Description : DEPTH-stage register pipeline used to align per-pixel control
//                with the sprite ROM read latency. All stages clear on reset.
//  Ports       : clk    - clock
//                rst_n  - synchronous active-low reset
//                d_i    - WIDTH-bit input
//                q_o    - input delayed by DEPTH cycles
//  Revision    : 1.0  initial release
// ============================================================================
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_compositor
//  Description : Multi-layer sprite compositor for the VGA pixel path. Each
//                sprite is hit-tested against the current pixel, its ROM is
//                addressed (with optional horizontal flip), and after the ROM
//                latency the lowest-index opaque sprite wins over a
//                state-dependent background. Sprite-0 collisions against the
//                other layers are accumulated per frame.
//  Ports       : VGA_clk, rst_n         - pixel clock, sync active-low reset
//                display_on, frame_start, X, Y - raster timing inputs
//                game_state             - 0 start,1 play,2 pause,3 win,4 lose
//                sprite_en/flip/x/y/frame - per-sprite controls (packed)
//                rom_row/col/frame      - per-sprite ROM address outputs
//                rom_data               - per-sprite ROM colour, ROM_LATENCY late
//                RGB                    - registered composited pixel
//                collide                - per-frame collision flags (bit 0 = 0)
//  Revision    : 1.0  initial release
// ============================================================================
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int          NUM_SPRITES = 4,
    parameter int          SPRITE_W    = 37,
    parameter int          SPRITE_H    = 42,
    parameter int          FRAME_W     = 2,
    parameter int          ROM_LATENCY = 1,
    parameter logic [23:0] TRANSPARENT = TRANSPARENT_KEY,
    parameter logic [23:0] BG_COLOUR   = BG_PLAY
) (
    input  logic                           VGA_clk,
    input  logic                           rst_n,
    input  logic                           display_on,
    input  logic                           frame_start,
    input  logic [15:0]                    X,
    input  logic [15:0]                    Y,
    input  logic [3:0]                     game_state,
    input  logic [NUM_SPRITES-1:0]         sprite_en,
    input  logic [NUM_SPRITES-1:0]         sprite_flip,
    input  logic [16*NUM_SPRITES-1:0]      sprite_x,
    input  logic [16*NUM_SPRITES-1:0]      sprite_y,
    input  logic [FRAME_W*NUM_SPRITES-1:0] sprite_frame,
    output logic [16*NUM_SPRITES-1:0]      rom_row,
    output logic [16*NUM_SPRITES-1:0]      rom_col,
    output logic [FRAME_W*NUM_SPRITES-1:0] rom_frame,
    input  logic [24*NUM_SPRITES-1:0]      rom_data,
    output logic [23:0]                    RGB,
    output logic [NUM_SPRITES-1:0]         collide
);

    localparam logic [COORD_W-1:0] c_SPRITE_W = COORD_W'(SPRITE_W);
    localparam logic [COORD_W-1:0] c_SPRITE_H = COORD_W'(SPRITE_H);
    localparam logic [COORD_W-1:0] c_LAST_COL = COORD_W'(SPRITE_W - 1);

    // ------------------------------------------------------------------
    // Hit test and ROM addressing. Offsets use wrapping subtraction, so a
    // pixel left of / above a sprite becomes a huge offset and misses.
    // ------------------------------------------------------------------
    logic [NUM_SPRITES-1:0] hit_w;

    generate
        for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sprite
            logic [COORD_W-1:0] dx_w;
            logic [COORD_W-1:0] dy_w;

            assign dx_w     = X - sprite_x[COORD_W*i +: COORD_W];
            assign dy_w     = Y - sprite_y[COORD_W*i +: COORD_W];
            assign hit_w[i] = sprite_en[i] & (dx_w < c_SPRITE_W) & (dy_w < c_SPRITE_H);

            // Addresses are driven regardless of hit; data is discarded later.
            assign rom_row[COORD_W*i +: COORD_W] = dy_w;
            assign rom_col[COORD_W*i +: COORD_W] = sprite_flip[i] ? (c_LAST_COL - dx_w) : dx_w;
        end
    endgenerate

    assign rom_frame = sprite_frame;

    // ------------------------------------------------------------------
    // Align per-pixel control with the returning ROM data.
    // ------------------------------------------------------------------
    logic [NUM_SPRITES-1:0] hit_dly_w;
    logic                   disp_dly_w;
    logic                   fs_dly_w;
    logic [GS_W-1:0]        gs_dly_w;

    delay_line #(.WIDTH(NUM_SPRITES), .DEPTH(ROM_LATENCY)) u_dly_hit (
        .clk(VGA_clk), .rst_n(rst_n), .d_i(hit_w),       .q_o(hit_dly_w)
    );
    delay_line #(.WIDTH(1),           .DEPTH(ROM_LATENCY)) u_dly_disp (
        .clk(VGA_clk), .rst_n(rst_n), .d_i(display_on),  .q_o(disp_dly_w)
    );
    delay_line #(.WIDTH(1),           .DEPTH(ROM_LATENCY)) u_dly_fs (
        .clk(VGA_clk), .rst_n(rst_n), .d_i(frame_start), .q_o(fs_dly_w)
    );
    delay_line #(.WIDTH(GS_W),        .DEPTH(ROM_LATENCY)) u_dly_gs (
        .clk(VGA_clk), .rst_n(rst_n), .d_i(game_state),  .q_o(gs_dly_w)
    );

    // ------------------------------------------------------------------
    // Opacity and background selection.
    // ------------------------------------------------------------------
    logic [NUM_SPRITES-1:0] opaque_w;
    logic [23:0]            bg_w;

    generate
        for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_opaque
            assign opaque_w[i] = hit_dly_w[i] & (rom_data[24*i +: 24] != TRANSPARENT);
        end
    endgenerate

    always_comb begin
        bg_w = '0;
        case (gs_dly_w)
            GS_PLAY, GS_PAUSE: bg_w = BG_COLOUR;
            GS_WIN:            bg_w = BG_WIN;
            GS_LOSE:           bg_w = BG_LOSE;
            default:           bg_w = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Priority chain: the highest index falls back to the background and
    // each lower index overrides everything above it when opaque, so link 0
    // carries the lowest-index opaque colour.
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_prio
            logic [23:0] sel_w;
            if (i == NUM_SPRITES - 1) begin : g_tail
                assign sel_w = opaque_w[i] ? rom_data[24*i +: 24] : bg_w;
            end else begin : g_link
                assign sel_w = opaque_w[i] ? rom_data[24*i +: 24] : g_prio[i+1].sel_w;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Compose and collision next-state.
    // ------------------------------------------------------------------
    logic [23:0]            rgb_d,     rgb_q;
    logic [NUM_SPRITES-1:0] collide_d, collide_q;
    logic [NUM_SPRITES-1:0] sticky_d,  sticky_q;
    logic [NUM_SPRITES-1:0] contrib_w;
    logic                   active_w;

    assign active_w = is_active_state(gs_dly_w);

    always_comb begin
        rgb_d = '0;
        if (disp_dly_w) begin
            case (gs_dly_w)
                GS_PLAY, GS_WIN, GS_LOSE: rgb_d = g_prio[0].sel_w;
                GS_PAUSE:                 rgb_d = halve_channels(g_prio[0].sel_w);
                default:                  rgb_d = '0;
            endcase
        end
    end

    // Sprite 0 never collides with itself, so bit 0 stays clear.
    always_comb begin
        contrib_w = '0;
        for (int i = 1; i < NUM_SPRITES; i++) begin
            contrib_w[i] = opaque_w[0] & opaque_w[i] & disp_dly_w & active_w;
        end
    end

    // On the frame boundary the finished frame (plus this pixel) is
    // published and the new frame's accumulator starts from this pixel.
    always_comb begin
        collide_d = collide_q;
        sticky_d  = sticky_q | contrib_w;
        if (fs_dly_w) begin
            collide_d = sticky_q | contrib_w;
            sticky_d  = contrib_w;
        end
    end

    always_ff @(posedge VGA_clk) begin
        if (!rst_n) begin
            rgb_q     <= '0;
            collide_q <= '0;
            sticky_q  <= '0;
        end else begin
            rgb_q     <= rgb_d;
            collide_q <= collide_d;
            sticky_q  <= sticky_d;
        end
    end

    assign RGB     = rgb_q;
    assign collide = collide_q;

endmodule
`default_nettype wire

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised multi-sprite pixel compositor for the VGA path. It generalises the single-player renderer to NUM_SPRITES layers, each with its own enable, position, horizontal flip and animation frame, and applies fixed-priority transparency-keyed overlay. It aligns all per-pixel control with a configurable ROM read latency, applies game-state colour modes and reports per-frame sprite-0 collisions. It sits between the VGA timing generator (X, Y, display_on, frame_start) and the DAC/RGB output register.

## Interface
- NUM_SPRITES, 4, number of sprite layers; index 0 is the player and has highest priority.
- SPRITE_W, 37, sprite width in pixels (all layers).
- SPRITE_H, 42, sprite height in pixels.
- FRAME_W, 2, animation-frame select width per sprite.
- ROM_LATENCY, 1, sprite ROM read latency in cycles, 1..4.
- TRANSPARENT, 24'hFF0096, colour key treated as transparent.
- BG_COLOUR, 24'h2222EE, play/pause background.

Ports:
- VGA_clk  in  1  pixel clock.
- rst_n  in  1  **One clock; reset is synchronous and active-low.**
- display_on  in  1  active-video qualifier, aligned with X/Y.
- frame_start  in  1  one-cycle pulse on the first pixel of each frame, aligned with X/Y.
- X, Y  in  16 each  current pixel coordinate.
- game_state  in  4  0 start, 1 play, 2 pause, 3 win, 4 lose.
- sprite_en  in  NUM_SPRITES  per-sprite enable.
- sprite_flip  in  NUM_SPRITES  1 = mirror horizontally.
- sprite_x, sprite_y  in  16·NUM_SPRITES each  top-left sprite positions, packed with sprite i at [16i+15:16i].
- sprite_frame  in  FRAME_W·NUM_SPRITES  animation frame per sprite.
- rom_row  out  16·NUM_SPRITES  ROM row address per sprite.
- rom_col  out  16·NUM_SPRITES  ROM column address per sprite.
- rom_frame  out  FRAME_W·NUM_SPRITES  ROM frame select per sprite.
- rom_data  in  24·NUM_SPRITES  ROM colour data, returned ROM_LATENCY cycles after the address.
- RGB  out  24  composited pixel (registered).
- collide  out  NUM_SPRITES  per-frame collision flags. Bit 0 is always 0.

## Operation
- Hit test per sprite, combinational, using 16-bit unsigned wrapping subtraction:
  - dx = X − sprite_x[i], dy = Y − sprite_y[i].
  - hit[i] = sprite_en[i] & (dx < SPRITE_W) & (dy < SPRITE_H).
  - Coordinates left of or above the sprite wrap to large values and miss.
- ROM addressing, combinational:
  - rom_row = dy.
  - rom_col = flip ? SPRITE_W−1−dx : dx.
  - rom_frame = sprite_frame.
  - Addresses are driven even when hit is 0. The data is ignored in that case.
- Alignment: hit[], display_on, frame_start and game_state pass through a ROM_LATENCY-deep shift register (delay_line) so they coincide with rom_data.
- opaque[i] = hit_d[i] & (rom_data[i] != TRANSPARENT).
- Compose stage, one register, selected by delayed game_state:
  - display_on_d = 0 → RGB = 0, regardless of state.
  - State 0, or any state above 4 → RGB = 0.
  - State 1 → colour of the lowest-index opaque sprite; BG_COLOUR if none is opaque.
  - State 2 → same as state 1, with each 8-bit channel shifted right by 1.
  - State 3 → same as state 1, with background 24'h00AA00.
  - State 4 → same as state 1, with background 24'hAA0000.
- Collision detection:
  - sticky[i], for i ≥ 1, is set when opaque[0] & opaque[i] & display_on_d, in states 1–4 only.
  - On frame_start_d: collide ← sticky (including the current pixel's contribution), then sticky ← the current pixel's contribution only.
  - collide holds its value for the whole of the following frame.

## Timing
- Latency from X/Y to RGB is ROM_LATENCY+1 cycles. Throughput is one pixel per cycle with no stalls.
- collide updates on the clock edge where frame_start_d is high, i.e. ROM_LATENCY+1 cycles after the frame_start input.
- Reset: while rst_n is low at a clock edge, RGB, collide, sticky and all delay-line stages (hit, display_on, frame_start, game_state) go to 0.
  - Because the delayed display_on is cleared, RGB stays 0 for ROM_LATENCY+1 cycles after release.
  - Releasing reset mid-line or mid-frame is legal. The first collide update occurs at the next frame_start.
- A game_state change takes effect on the pixel whose X/Y was presented in the same cycle, since state is delayed alongside that pixel.
- Sprite position, enable and flip changes are sampled each cycle. Upstream updates them only during blanking; the block adds no shadow registers.

## Structure
- Shared package sprite_pkg: state encodings (GS_START..GS_LOSE), TRANSPARENT, background colours for each state, COORD_W = 16.
- Sub-module delay_line (params WIDTH, DEPTH) handles latency alignment. It is reset-clearable, uses synchronous active-low reset, and is reused for every delayed signal.
- Priority selection is a generate-built chain from the highest index down to 0.
- Expected size: 150–300 lines of RTL.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with display_on=1 and state 1 → RGB=0 and collide=0; RGB=BG_COLOUR from cycle ROM_LATENCY+1 after release.
- Single sprite: sprite 0 at (100,50), flip=0, X=100, Y=50, ROM column 0 returns 24'h123456 → RGB=24'h123456 after ROM_LATENCY+1 cycles. With flip=1, rom_col=36 for the same pixel.
- Priority and transparency: sprites 0 and 2 overlap, sprite 0 returns FF0096 and sprite 2 returns 24'h00FF00 → RGB=24'h00FF00. When sprite 0 returns 24'hFFFFFF, RGB=24'hFFFFFF.
- Wrap and boundary: sprite_x=100; X=99 → miss (dx wraps to 65535); X=136 → hit; X=137 → miss.
- Collision: sprites 0 and 3 both opaque at one pixel in frame N → collide=4'b1000 after frame N+1's frame_start_d; a frame with no overlap → collide=0 at the following frame_start_d.
- Modes: pause with sprite colour 24'hFF8040 → RGB=24'h7F4020; lose with no sprite → 24'hAA0000; state 7 → 0; display_on=0 in any state → 0.
